// File: rtl/aib_avmm_arb_pkg.sv
// Shared types and constants for the AIB AVMM configuration-bus arbiter.
package aib_avmm_arb_pkg;

    localparam int         ADDR_W    = 21;
    localparam int         DATA_W    = 8;
    localparam logic [7:0] ERR_RDATA = 8'hEE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_AVMM1 = 2'd0,
        REQ_AVMM2 = 2'd1,
        REQ_HIP   = 2'd2
    } req_idx_t;

    function automatic req_idx_t onehot_to_idx(input logic [2:0] oh);
        case (oh)
            3'b010:  return REQ_AVMM2;
            3'b100:  return REQ_HIP;
            default: return REQ_AVMM1;
        endcase
    endfunction

endpackage

// File: rtl/aib_avmm_cfg_arb_if.sv
// Requester and CSR-target signal bundle for the AVMM configuration arbiter.
interface aib_avmm_cfg_arb_if;

    logic        avmm1_request, avmm1_read, avmm1_write;
    logic [9:0]  avmm1_reg_addr;
    logic [7:0]  avmm1_writedata;
    logic        avmm2_request, avmm2_read, avmm2_write;
    logic [8:0]  avmm2_reg_addr;
    logic [7:0]  avmm2_writedata;
    logic        hip_request, hip_read, hip_write;
    logic [20:0] hip_reg_addr;
    logic [7:0]  hip_writedata;

    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        err;
    logic [7:0]  rdata;

    // Target handshake: tgt_read/tgt_write is accepted on an edge where
    // tgt_waitrequest is low; until then command, address and wdata are held.
    // Read data is taken on an edge with tgt_rdatavalid high while in WAIT_RD.
    logic        tgt_read, tgt_write;
    logic [20:0] tgt_addr;
    logic [7:0]  tgt_wdata;
    logic        tgt_waitrequest;
    logic        tgt_rdatavalid;
    logic [7:0]  tgt_rdata;

    aib_avmm_arb_pkg::state_t dbg_state;

    modport slave (
        input  avmm1_request, avmm1_read, avmm1_write, avmm1_reg_addr, avmm1_writedata,
        input  avmm2_request, avmm2_read, avmm2_write, avmm2_reg_addr, avmm2_writedata,
        input  hip_request, hip_read, hip_write, hip_reg_addr, hip_writedata,
        input  tgt_waitrequest, tgt_rdatavalid, tgt_rdata,
        output gnt, done, err, rdata,
        output tgt_read, tgt_write, tgt_addr, tgt_wdata,
        output dbg_state
    );

    modport master (
        output avmm1_request, avmm1_read, avmm1_write, avmm1_reg_addr, avmm1_writedata,
        output avmm2_request, avmm2_read, avmm2_write, avmm2_reg_addr, avmm2_writedata,
        output hip_request, hip_read, hip_write, hip_reg_addr, hip_writedata,
        output tgt_waitrequest, tgt_rdatavalid, tgt_rdata,
        input  gnt, done, err, rdata,
        input  tgt_read, tgt_write, tgt_addr, tgt_wdata,
        input  dbg_state
    );

endinterface

// File: rtl/aib_avmm_rr_arb.sv
// Combinational 3-way round-robin picker; search starts after the last winner.
module aib_avmm_rr_arb
    import aib_avmm_arb_pkg::*;
(
    input  logic [2:0] req,
    input  req_idx_t   last,
    output logic [2:0] grant,
    output logic       valid
);

    always_comb begin
        grant = 3'b000;
        case (last)
            REQ_AVMM1: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            REQ_AVMM2: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/aib_avmm_cfg_arb.sv
// Round-robin arbiter sharing one 21-bit/8-bit CSR target among PLD AVMM1,
// PLD AVMM2 and HIP AVMM; one transaction at a time, registered outputs.
module aib_avmm_cfg_arb
    import aib_avmm_arb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] AVMM1_BASE  = 21'h00000,
    parameter logic [ADDR_W-1:0] AVMM2_BASE  = 21'h00400,
    parameter int                TIMEOUT_CYC = 64
) (
    input  logic               avmm_clk,
    input  logic               avmm_rst_n,
    aib_avmm_cfg_arb_if.slave  bus
);

    localparam logic [8:0] TMO_LIM = 9'(TIMEOUT_CYC);

    state_t              state_q, state_d;
    req_idx_t            last_q, last_d, owner_q, owner_d, pick_idx;
    logic [2:0]          gnt_q, gnt_d, done_q, done_d, pick, req_vec;
    logic                err_q, err_d, is_rd_q, is_rd_d, pick_valid;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic [7:0]          rdata_q, rdata_d, wdata_q, wdata_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, sel_addr;
    logic [7:0]          sel_wdata;
    logic                sel_rd, sel_wr, sel_legal, tmo;
    logic [8:0]          cnt_inc;

    assign req_vec = {bus.hip_request, bus.avmm2_request, bus.avmm1_request};

    aib_avmm_rr_arb u_rr (
        .req   (req_vec),
        .last  (last_q),
        .grant (pick),
        .valid (pick_valid)
    );

    assign pick_idx = onehot_to_idx(pick);

    // Narrow requesters are zero-extended and relocated; the sum wraps mod 2^21.
    always_comb begin
        sel_rd    = bus.hip_read;
        sel_wr    = bus.hip_write;
        sel_addr  = bus.hip_reg_addr;
        sel_wdata = bus.hip_writedata;
        case (pick_idx)
            REQ_AVMM1: begin
                sel_rd    = bus.avmm1_read;
                sel_wr    = bus.avmm1_write;
                sel_addr  = AVMM1_BASE + ADDR_W'(bus.avmm1_reg_addr);
                sel_wdata = bus.avmm1_writedata;
            end
            REQ_AVMM2: begin
                sel_rd    = bus.avmm2_read;
                sel_wr    = bus.avmm2_write;
                sel_addr  = AVMM2_BASE + ADDR_W'(bus.avmm2_reg_addr);
                sel_wdata = bus.avmm2_writedata;
            end
            default: ;
        endcase
    end

    assign sel_legal = sel_rd ^ sel_wr;
    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    assign tmo       = (cnt_inc >= TMO_LIM);

    always_ff @(posedge avmm_clk) begin
        if (!avmm_rst_n) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Completion (acceptance or read data) takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = sel_legal ? ISSUE : DONE;
            ISSUE:   if (!bus.tgt_waitrequest) state_d = is_rd_q ? WAIT_RD : DONE;
                     else if (tmo) state_d = DONE;
            WAIT_RD: if (bus.tgt_rdatavalid || tmo) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = gnt_q;
        done_d  = 3'b000;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        is_rd_d = is_rd_q;
        case (state_q)
            IDLE: if (pick_valid) begin
                gnt_d   = pick;
                owner_d = pick_idx;
                cnt_d   = 8'd0;
                addr_d  = sel_addr;
                wdata_d = sel_wdata;
                is_rd_d = sel_rd;
                if (sel_legal) begin
                    rd_d = sel_rd;
                    wr_d = sel_wr;
                end else begin
                    done_d  = pick;
                    err_d   = 1'b1;
                    rdata_d = 8'h00;
                end
            end
            ISSUE: begin
                cnt_d = cnt_inc[7:0];
                if (!bus.tgt_waitrequest) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (!is_rd_q) begin
                        done_d  = gnt_q;
                        rdata_d = 8'h00;
                    end
                end else if (tmo) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_inc[7:0];
                if (bus.tgt_rdatavalid) begin
                    done_d  = gnt_q;
                    rdata_d = bus.tgt_rdata;
                end else if (tmo) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                end
            end
            DONE: begin
                gnt_d  = 3'b000;
                last_d = owner_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge avmm_clk) begin
        if (!avmm_rst_n) begin
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            cnt_q   <= 8'd0;
            last_q  <= REQ_HIP;
            owner_q <= REQ_AVMM1;
            is_rd_q <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            is_rd_q <= is_rd_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.tgt_read  = rd_q;
    assign bus.tgt_write = wr_q;
    assign bus.tgt_addr  = addr_q;
    assign bus.tgt_wdata = wdata_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_aib_avmm_cfg_arb.sv
// Bench for aib_avmm_cfg_arb: directed and random transactions against a
// round-robin/timing reference model with an emulated CSR target.
module tb_aib_avmm_cfg_arb;
    import aib_avmm_arb_pkg::*;

    localparam int          T  = 64;
    localparam logic [20:0] B1 = 21'h00000;
    localparam logic [20:0] B2 = 21'h00400;

    logic avmm_clk   = 1'b0;
    logic avmm_rst_n = 1'b0;

    aib_avmm_cfg_arb_if bus();

    aib_avmm_cfg_arb #(
        .AVMM1_BASE  (B1),
        .AVMM2_BASE  (B2),
        .TIMEOUT_CYC (T)
    ) dut (
        .avmm_clk   (avmm_clk),
        .avmm_rst_n (avmm_rst_n),
        .bus        (bus)
    );

    always #5 avmm_clk = ~avmm_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rr_last = 2;

    logic        cmd_rd [3];
    logic        cmd_wr [3];
    logic [7:0]  cmd_wd [3];
    logic [9:0]  a1;
    logic [8:0]  a2;
    logic [20:0] ah;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge avmm_clk);
        #1;
    endtask

    function automatic int model_pick(input logic [2:0] req);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (rr_last + k) % 3;
            if (((req >> idx) & 3'b001) != 3'b000) return idx;
        end
        return -1;
    endfunction

    function automatic int exp_addr(input int w);
        if (w == 0) return (int'(B1) + int'(a1)) % (1 << 21);
        if (w == 1) return (int'(B2) + int'(a2)) % (1 << 21);
        return int'(ah);
    endfunction

    task automatic set_cmd(input int r, input logic rd, input logic wr,
                           input logic [20:0] addr, input logic [7:0] wd);
        cmd_rd[2'(r)] = rd;
        cmd_wr[2'(r)] = wr;
        cmd_wd[2'(r)] = wd;
        if (r == 0) a1 = addr[9:0];
        else if (r == 1) a2 = addr[8:0];
        else ah = addr;
    endtask

    task automatic drive_reqs(input logic [2:0] req);
        bus.avmm1_request = req[0]; bus.avmm1_read = cmd_rd[0]; bus.avmm1_write = cmd_wr[0];
        bus.avmm1_reg_addr = a1;    bus.avmm1_writedata = cmd_wd[0];
        bus.avmm2_request = req[1]; bus.avmm2_read = cmd_rd[1]; bus.avmm2_write = cmd_wr[1];
        bus.avmm2_reg_addr = a2;    bus.avmm2_writedata = cmd_wd[1];
        bus.hip_request = req[2];   bus.hip_read = cmd_rd[2];   bus.hip_write = cmd_wr[2];
        bus.hip_reg_addr = ah;      bus.hip_writedata = cmd_wd[2];
    endtask

    // Disturb a dropped requester's command to show the grant latched it.
    task automatic scramble(input int w);
        if (w == 0) begin
            bus.avmm1_reg_addr = 10'($urandom); bus.avmm1_writedata = 8'($urandom);
            bus.avmm1_read = 1'($urandom);      bus.avmm1_write = 1'($urandom);
        end else if (w == 1) begin
            bus.avmm2_reg_addr = 9'($urandom);  bus.avmm2_writedata = 8'($urandom);
            bus.avmm2_read = 1'($urandom);      bus.avmm2_write = 1'($urandom);
        end else begin
            bus.hip_reg_addr = 21'($urandom);   bus.hip_writedata = 8'($urandom);
            bus.hip_read = 1'($urandom);        bus.hip_write = 1'($urandom);
        end
    endtask

    task automatic serve(input logic [2:0] req, input int ws, input int rd_lat,
                         input logic [7:0] rdv, input bit never_valid, input bit drop,
                         output int got_w);
        int w, c, exp_step, gnt_step, cmd_step, done_step, acc_step, wcnt, unstable;
        bit legal, is_rd, exp_err, chk_rd, saw_cmd, accepted, got_done, dropped;
        logic [7:0]  exp_rdata, d0, rdata_v;
        logic [20:0] a0;
        logic        r0, w0, err_v;
        logic [2:0]  req_cur, done_v, gnt_v, oh;
        w  = model_pick(req);
        oh = 3'b001 << w;
        legal = cmd_rd[2'(w)] ^ cmd_wr[2'(w)];
        is_rd = legal && cmd_rd[2'(w)];
        exp_rdata = 8'h00;
        chk_rd = 1'b1;
        if (!legal) begin
            exp_step = 1; exp_err = 1'b1;
        end else begin
            c = is_rd ? (never_valid ? 100000 : ws + 1 + rd_lat) : ws + 1;
            if (c <= T) begin
                exp_step = 1 + c; exp_err = 1'b0;
                exp_rdata = rdv; chk_rd = is_rd;
            end else begin
                exp_step = 1 + T; exp_err = 1'b1; exp_rdata = ERR_RDATA;
            end
        end
        gnt_step = -1; cmd_step = -1; done_step = -1; acc_step = -1;
        wcnt = 0; unstable = 0; saw_cmd = 0; accepted = 0; got_done = 0; dropped = 0;
        a0 = '0; d0 = '0; r0 = 1'b0; w0 = 1'b0;
        done_v = '0; gnt_v = '0; err_v = 1'b0; rdata_v = '0;
        req_cur = req;
        drive_reqs(req_cur);
        for (int s = 1; s <= 300 && !got_done; s++) begin
            tick();
            if (bus.gnt != 3'b000 && gnt_step < 0) gnt_step = s;
            if (bus.done != 3'b000) begin
                got_done = 1; done_step = s;
                done_v = bus.done; gnt_v = bus.gnt; err_v = bus.err; rdata_v = bus.rdata;
            end else begin
                if (bus.tgt_read || bus.tgt_write) begin
                    if (!saw_cmd) begin
                        saw_cmd = 1; cmd_step = s;
                        a0 = bus.tgt_addr; d0 = bus.tgt_wdata; r0 = bus.tgt_read; w0 = bus.tgt_write;
                    end else if (bus.tgt_addr !== a0 || bus.tgt_wdata !== d0 ||
                                 bus.tgt_read !== r0 || bus.tgt_write !== w0) begin
                        unstable++;
                    end
                end
                if (drop && gnt_step >= 0 && !dropped) begin
                    dropped = 1;
                    req_cur = req_cur & ~oh;
                    drive_reqs(req_cur);
                    scramble(w);
                end
                if ((bus.tgt_read || bus.tgt_write) && !accepted) begin
                    if (wcnt < ws) begin
                        bus.tgt_waitrequest = 1'b1; wcnt++;
                    end else begin
                        bus.tgt_waitrequest = 1'b0; accepted = 1; acc_step = s;
                    end
                end else begin
                    bus.tgt_waitrequest = 1'($urandom_range(0, 1));
                end
                bus.tgt_rdata = 8'($urandom);
                if (accepted && r0) begin
                    bus.tgt_rdatavalid = (!never_valid && (s - acc_step) == rd_lat);
                    if (bus.tgt_rdatavalid) bus.tgt_rdata = rdv;
                end else begin
                    bus.tgt_rdatavalid = 1'($urandom_range(0, 1));
                end
            end
        end
        bus.tgt_rdatavalid  = 1'b0;
        bus.tgt_waitrequest = 1'b0;
        case (done_v)
            3'b001:  got_w = 0;
            3'b010:  got_w = 1;
            3'b100:  got_w = 2;
            default: got_w = -1;
        endcase
        check("done_seen", 32'(got_done), 32'd1);
        if (got_done) begin
            check("done_vec", 32'(done_v), 32'(oh));
            check("gnt_at_done", 32'(gnt_v), 32'(oh));
            check("gnt_lat", 32'(gnt_step), 32'd1);
            check("done_lat", 32'(done_step), 32'(exp_step));
            check("err", 32'(err_v), 32'(exp_err));
            if (chk_rd) check("rdata", 32'(rdata_v), 32'(exp_rdata));
            check("cmd_seen", 32'(saw_cmd), 32'(legal));
            if (legal && saw_cmd) begin
                check("cmd_lat", 32'(cmd_step), 32'd1);
                check("tgt_addr", 32'(a0), 32'(exp_addr(w)));
                check("tgt_cmd", 32'({r0, w0}), 32'({is_rd, !is_rd}));
                if (!is_rd) check("tgt_wdata", 32'(d0), 32'(cmd_wd[2'(w)]));
                check("cmd_stable", 32'(unstable), 32'd0);
            end
            tick();
            check("done_pulse", 32'(bus.done), 32'd0);
            check("gnt_clear", 32'(bus.gnt), 32'd0);
            check("cmd_idle", 32'({bus.tgt_read, bus.tgt_write}), 32'd0);
            rr_last = w;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_err"},   32'(bus.err), 32'd0);
        check({tag, "_cmd"},   32'({bus.tgt_read, bus.tgt_write}), 32'd0);
        check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
        check({tag, "_addr"},  32'(bus.tgt_addr), 32'd0);
        check({tag, "_wdata"}, 32'(bus.tgt_wdata), 32'd0);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'(IDLE));
    endtask

    initial begin
        int w;
        for (int r = 0; r < 3; r++) set_cmd(r, 1'b0, 1'b0, 21'd0, 8'd0);
        drive_reqs(3'b000);
        bus.tgt_waitrequest = 1'b0;
        bus.tgt_rdatavalid  = 1'b0;
        bus.tgt_rdata       = 8'h00;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        avmm_rst_n = 1'b1;
        tick();

        // avmm1 write, no wait states
        set_cmd(0, 1'b0, 1'b1, 21'h005, 8'hA5);
        serve(3'b001, 0, 1, 8'h00, 1'b0, 1'b0, w);
        // avmm2 read with three wait states, data two cycles after acceptance
        set_cmd(1, 1'b1, 1'b0, 21'h010, 8'h00);
        serve(3'b010, 3, 2, 8'h3C, 1'b0, 1'b0, w);
        set_cmd(2, 1'b0, 1'b1, 21'h1F_FF00, 8'h11);
        serve(3'b100, 1, 1, 8'h00, 1'b0, 1'b0, w);

        // Fairness with all three requests held
        set_cmd(0, 1'b0, 1'b1, 21'h020, 8'h01);
        set_cmd(1, 1'b0, 1'b1, 21'h1FF, 8'h02);
        set_cmd(2, 1'b0, 1'b1, 21'h12345, 8'h03);
        for (int i = 0; i < 6; i++) begin
            serve(3'b111, 0, 1, 8'h00, 1'b0, 1'b0, w);
            check("rr_order", 32'(w), 32'(i % 3));
        end

        // Read timeout, then a normal transaction
        set_cmd(2, 1'b1, 1'b0, 21'h0ABCD, 8'h00);
        serve(3'b100, 0, 1, 8'h00, 1'b1, 1'b0, w);
        set_cmd(1, 1'b0, 1'b1, 21'h0F0, 8'h5A);
        serve(3'b010, 2, 1, 8'h00, 1'b0, 1'b0, w);

        // Data arriving on the timeout cycle wins; one cycle later it does not
        serve(3'b100, 0, T - 1, 8'h5A, 1'b0, 1'b0, w);
        serve(3'b100, 0, T, 8'h5A, 1'b0, 1'b0, w);

        // Illegal commands
        set_cmd(0, 1'b1, 1'b1, 21'h033, 8'h44);
        serve(3'b001, 0, 1, 8'h00, 1'b0, 1'b0, w);
        set_cmd(1, 1'b0, 1'b0, 21'h034, 8'h45);
        serve(3'b010, 0, 1, 8'h00, 1'b0, 1'b0, w);

        // Random traffic with stray target inputs and dropped requests
        for (int i = 0; i < 30; i++) begin
            for (int r = 0; r < 3; r++) begin
                int k;
                bit b;
                k = $urandom_range(0, 9);
                b = 1'($urandom_range(0, 1));
                if (k == 0)      set_cmd(r, b, b, 21'($urandom), 8'($urandom));
                else if (k < 5)  set_cmd(r, 1'b0, 1'b1, 21'($urandom), 8'($urandom));
                else             set_cmd(r, 1'b1, 1'b0, 21'($urandom), 8'($urandom));
            end
            serve(3'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(1, 4),
                  8'($urandom), 1'b0, 1'($urandom_range(0, 1)), w);
        end

        // Reset during WAIT_RD
        set_cmd(0, 1'b1, 1'b0, 21'h123, 8'h00);
        drive_reqs(3'b001);
        bus.tgt_waitrequest = 1'b0;
        bus.tgt_rdatavalid  = 1'b0;
        tick();
        check("rst_rd_issue", 32'(bus.tgt_read), 32'd1);
        drive_reqs(3'b000);
        tick();
        check("rst_rd_wait", 32'(bus.dbg_state), 32'(WAIT_RD));
        avmm_rst_n = 1'b0;
        bus.tgt_rdatavalid = 1'b1;
        bus.tgt_rdata = 8'h77;
        tick();
        check_reset_outputs("midrst");
        bus.tgt_rdatavalid = 1'b0;
        tick();
        check("midrst_no_done", 32'(bus.done), 32'd0);
        avmm_rst_n = 1'b1;
        rr_last = 2;
        tick();
        set_cmd(0, 1'b0, 1'b1, 21'h001, 8'h9C);
        set_cmd(1, 1'b0, 1'b1, 21'h002, 8'h9D);
        set_cmd(2, 1'b0, 1'b1, 21'h003, 8'h9E);
        serve(3'b111, 0, 1, 8'h00, 1'b0, 1'b0, w);
        check("post_rst_first", 32'(w), 32'd0);
        drive_reqs(3'b000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
